// File: rtl/opb_reorder_pkg.sv
// Shared helpers for the operand-B reorder unit: digit-permutation source index and clog2.
// Default geometry localparams match the 8-bit / 2-bit-leaf configuration.
package opb_reorder_pkg;

    function automatic int unsigned opb_clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    localparam int unsigned DEF_PRECISION   = 8;
    localparam int unsigned DEF_L_PRECISION = 2;
    localparam int unsigned DEF_N           = DEF_PRECISION / DEF_L_PRECISION;
    localparam int unsigned DEF_NUM_LEVELS  = opb_clog2(DEF_N);

    // Source digit for destination digit dst after one level on an n x n grid.
    // Sub-blocks are contiguous runs of s*s digits, each laid out row-major.
    function automatic int unsigned src_index(input int unsigned n, input int unsigned level,
                                              input bit transpose, input int unsigned dst);
        int unsigned s, h, blk, loc, q, p, qr, qc, pr, pc;
        s = n >> level;
        if (s < 2) return dst;
        h   = s / 2;
        blk = dst / (s * s);
        loc = dst % (s * s);
        q   = loc / (h * h);
        p   = loc % (h * h);
        if (transpose) begin
            qr = q & 1;
            qc = q >> 1;
            pc = p / h;
            pr = p % h;
        end else begin
            qr = q >> 1;
            qc = q & 1;
            pr = p / h;
            pc = p % h;
        end
        return blk * s * s + (qr * h + pr) * s + qc * h + pc;
    endfunction

endpackage

// File: rtl/opb_reorder_stage.sv
// One decomposition level: mode-conditional digit permutation into a valid/data/mode register.
// Reset is synchronous and active-low.
module opb_reorder_stage
    import opb_reorder_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned L_PRECISION = 2,
    parameter int unsigned MODE_W      = 2,
    parameter int unsigned LEVEL       = 0,
    parameter bit          TRANSPOSE   = 1'b0,
    localparam int unsigned DW         = N * N * L_PRECISION
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [DW-1:0]     data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [MODE_W-1:0] mode_o,
    output logic [DW-1:0]     data_o
);

    logic [DW-1:0]     perm;
    logic [DW-1:0]     data_d;
    logic              advance;
    logic              valid_q;
    logic [MODE_W-1:0] mode_q;
    logic [DW-1:0]     data_q;

    for (genvar d = 0; d < N * N; d++) begin : g_perm
        localparam int unsigned Src = src_index(N, LEVEL, TRANSPOSE, d);
        assign perm[d*L_PRECISION +: L_PRECISION] = data_i[Src*L_PRECISION +: L_PRECISION];
    end

    always_comb begin
        data_d  = data_i;
        if (32'(mode_i) > LEVEL) data_d = perm;
        advance = ~valid_q | ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            mode_q  <= '0;
            data_q  <= '0;
        end else if (advance) begin
            valid_q <= valid_i;
            if (valid_i) begin
                mode_q <= mode_i;
                data_q <= data_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = data_q;

endmodule

// File: rtl/operand_b_reorder.sv
// Precision-scalable operand-B reorder pipeline, one stage per decomposition level.
// Define OPB_REORDER_SKID_EN to add a 2-entry skid buffer with a registered in_ready.
module operand_b_reorder
    import opb_reorder_pkg::*;
#(
    parameter int unsigned PRECISION   = 8,
    parameter int unsigned L_PRECISION = 2,
    parameter int unsigned DATA_WIDTH  = (PRECISION / L_PRECISION) * PRECISION,
    parameter int unsigned NUM_LEVELS  = opb_clog2(PRECISION / L_PRECISION),
    parameter int unsigned MODE_W      = (opb_clog2(NUM_LEVELS + 1) < 1) ? 1
                                         : opb_clog2(NUM_LEVELS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MODE_W-1:0]     in_mode,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MODE_W-1:0]     out_mode,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  busy
);

    localparam int unsigned N       = PRECISION / L_PRECISION;
    localparam int unsigned NSTAGES = (NUM_LEVELS == 0) ? 1 : NUM_LEVELS;

    logic [MODE_W-1:0]     mode_sat;
    logic                  head_valid;
    logic                  head_ready;
    logic [MODE_W-1:0]     head_mode;
    logic [DATA_WIDTH-1:0] head_data;
    logic [NSTAGES-1:0]    stg_valid;
    logic [NSTAGES-1:0]    stg_down;
    logic [MODE_W-1:0]     stg_mode [NSTAGES];
    logic [DATA_WIDTH-1:0] stg_data [NSTAGES];

    always_comb begin
        mode_sat = in_mode;
        if (32'(in_mode) > NUM_LEVELS) mode_sat = MODE_W'(NUM_LEVELS);
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        logic                  s_valid;
        logic [MODE_W-1:0]     s_mode;
        logic [DATA_WIDTH-1:0] s_data;

        if (k == 0) begin : g_head
            assign s_valid = head_valid;
            assign s_mode  = head_mode;
            assign s_data  = head_data;
        end else begin : g_chain
            assign s_valid = stg_valid[k-1];
            assign s_mode  = stg_mode[k-1];
            assign s_data  = stg_data[k-1];
        end

        // Downstream accepts if the output port does or any later slot is empty.
        if (k == NSTAGES - 1) begin : g_last
            assign stg_down[k] = out_ready;
        end else begin : g_mid
            assign stg_down[k] = out_ready | ~(&stg_valid[NSTAGES-1:k+1]);
        end

        opb_reorder_stage #(
            .N          (N),
            .L_PRECISION(L_PRECISION),
            .MODE_W     (MODE_W),
            .LEVEL      (k),
            .TRANSPOSE  (k == 0)
        ) u_stage (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .valid_i(s_valid),
            .mode_i (s_mode),
            .data_i (s_data),
            .ready_i(stg_down[k]),
            .valid_o(stg_valid[k]),
            .mode_o (stg_mode[k]),
            .data_o (stg_data[k])
        );
    end

    assign head_ready = ~stg_valid[0] | stg_down[0];

`ifdef OPB_REORDER_SKID_EN
    logic [DATA_WIDTH-1:0] skid_data_q [2];
    logic [MODE_W-1:0]     skid_mode_q [2];
    logic                  skid_wr_q;
    logic                  skid_rd_q;
    logic [1:0]            skid_cnt_q;
    logic [1:0]            skid_cnt_d;
    logic                  in_ready_q;
    logic                  push;
    logic                  pop;

    assign push       = in_valid & in_ready_q;
    assign pop        = head_valid & head_ready;
    assign head_valid = (skid_cnt_q != 2'd0);
    assign head_mode  = skid_mode_q[skid_rd_q];
    assign head_data  = skid_data_q[skid_rd_q];

    always_comb begin
        skid_cnt_d = skid_cnt_q;
        case ({push, pop})
            2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
            2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
            default: skid_cnt_d = skid_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                skid_data_q[skid_wr_q] <= b_in;
                skid_mode_q[skid_wr_q] <= mode_sat;
                skid_wr_q              <= ~skid_wr_q;
            end
            if (pop) skid_rd_q <= ~skid_rd_q;
            skid_cnt_q <= skid_cnt_d;
            // Registered so in_ready has no combinational path from out_ready.
            in_ready_q <= (skid_cnt_d != 2'd2);
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = (|stg_valid) | head_valid;
`else
    assign head_valid = in_valid;
    assign head_mode  = mode_sat;
    assign head_data  = b_in;
    assign in_ready   = head_ready;
    assign busy       = |stg_valid;
`endif

    assign out_valid = stg_valid[NSTAGES-1];
    assign out_mode  = stg_mode[NSTAGES-1];
    assign b_out     = stg_data[NSTAGES-1];

endmodule

// File: tb/tb_operand_b_reorder.sv
// Bench for operand_b_reorder: directed digit-order checks on an N=4 instance and randomized
// scoreboard checks against a grid/quadrant reference model on an N=8 instance.
module tb_operand_b_reorder;

`ifdef OPB_REORDER_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    localparam int LAT   = 3 + SKID;
    localparam int LAT_S = 2 + SKID;
    localparam int CAP   = 3 + 2 * SKID;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         reset_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]   in_mode, out_mode;
    logic [127:0] b_in, b_out;

    logic        s_in_valid, s_in_ready, s_out_valid, s_busy;
    logic [1:0]  s_in_mode, s_out_mode;
    logic [31:0] s_b_in, s_b_out;

    operand_b_reorder #(.PRECISION(16), .L_PRECISION(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .b_out(b_out), .busy(busy)
    );

    operand_b_reorder #(.PRECISION(8), .L_PRECISION(2)) u_small (
        .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_mode(s_in_mode), .b_in(s_b_in), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_mode(s_out_mode), .b_out(s_b_out), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Walk the grid: every level cuts each block into quadrants and lists them in order.
    function automatic logic [127:0] model(input logic [127:0] b, input int n, input int mode);
        int src[64];
        int nxt[64];
        int nl, m, s, h, pos, base, r0, c0, r, c;
        logic [127:0] res;
        nl = 0;
        while ((1 << nl) < n) nl++;
        m = (mode > nl) ? nl : mode;
        for (int i = 0; i < 64; i++) src[i] = i;
        for (int k = 0; k < m; k++) begin
            s   = n >> k;
            h   = s / 2;
            pos = 0;
            for (int blk = 0; blk < (n * n) / (s * s); blk++) begin
                base = blk * s * s;
                for (int q = 0; q < 4; q++) begin
                    if (k == 0) begin
                        r0 = (q == 1 || q == 3) ? h : 0;
                        c0 = (q == 2 || q == 3) ? h : 0;
                    end else begin
                        r0 = (q >= 2) ? h : 0;
                        c0 = (q == 1 || q == 3) ? h : 0;
                    end
                    for (int a = 0; a < h; a++) begin
                        for (int bb = 0; bb < h; bb++) begin
                            if (k == 0) begin
                                c = c0 + a;
                                r = r0 + bb;
                            end else begin
                                r = r0 + a;
                                c = c0 + bb;
                            end
                            nxt[pos] = src[base + r * s + c];
                            pos++;
                        end
                    end
                end
            end
            src = nxt;
        end
        res = '0;
        for (int i = 0; i < n * n; i++) res[i*2 +: 2] = b[src[i]*2 +: 2];
        return res;
    endfunction

    // Scoreboard monitor on the N=8 instance.
    logic         mon_en = 1'b0;
    logic         strm   = 1'b0;
    logic         hold   = 1'b0;
    logic [129:0] hold_v;
    logic [129:0] exp_q[$];
    int           n_in = 0, n_out = 0, stalls = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold) chk("stall_hold", {out_valid, out_mode, b_out}, {1'b1, hold_v});
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL spurious_beat: observed %h expected no beat", b_out);
                end else begin
                    chk("beat", {out_mode, b_out}, exp_q.pop_front());
                end
            end
            hold   = out_valid && !out_ready;
            hold_v = {out_mode, b_out};
            if (in_valid && in_ready) begin
                exp_q.push_back({in_mode, model(b_in, 8, int'(in_mode))});
                n_in++;
            end
            if (strm && !in_ready) stalls++;
        end else begin
            hold = 1'b0;
        end
    end

    task automatic small_beat(input logic [1:0] m, input logic [31:0] d, input logic [31:0] e,
                              input logic [1:0] em, input string tag);
        int cyc;
        @(posedge clk) #1;
        s_in_valid = 1'b1;
        s_in_mode  = m;
        s_b_in     = d;
        @(posedge clk) #1;
        s_in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!s_out_valid && cyc < 20);
        chk({tag, "_lat"}, cyc, LAT_S);
        chk({tag, "_data"}, s_b_out, e);
        chk({tag, "_mode"}, s_out_mode, em);
    endtask

    task automatic main_lat(input string tag);
        int cyc;
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_mode  = 2'd3;
        b_in     = rnd128();
        @(posedge clk) #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        chk({tag, "_latency"}, cyc, LAT);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          order[16] = '{0, 4, 1, 5, 8, 12, 9, 13, 2, 6, 3, 7, 10, 14, 11, 15};
        logic [31:0] pat, exp1, rs, ers;
        int          n0;

        reset_n = 1'b0;  in_valid = 1'b0;  in_mode = '0;  b_in = '0;  out_ready = 1'b1;
        s_in_valid = 1'b0;  s_in_mode = '0;  s_b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_out_mode", out_mode, 0);
        @(posedge clk) #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_small_in_ready", s_in_ready, 1);

        // N=4 digit order per mode, with digit i = i mod 4 and with random digits.
        for (int i = 0; i < 16; i++) pat[2*i +: 2] = 2'(i % 4);
        for (int j = 0; j < 16; j++) exp1[2*j +: 2] = pat[2*order[j] +: 2];
        rs = $urandom();
        for (int j = 0; j < 16; j++) ers[2*j +: 2] = rs[2*order[j] +: 2];
        small_beat(2'd0, pat, pat, 2'd0, "s_mode0");
        small_beat(2'd1, pat, exp1, 2'd1, "s_mode1");
        small_beat(2'd2, pat, exp1, 2'd2, "s_mode2");
        small_beat(2'd3, pat, exp1, 2'd2, "s_mode3_sat");
        small_beat(2'd0, rs, rs, 2'd0, "s_rand_mode0");
        small_beat(2'd1, rs, ers, 2'd1, "s_rand_mode1");
        small_beat(2'd2, rs, ers, 2'd2, "s_rand_mode2");

        // N=8 latency and continuous streaming at mode 3.
        mon_en = 1'b1;
        main_lat("lat_a");
        main_lat("lat_b");
        strm = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk) #1;
            in_valid = 1'b1;  in_mode = 2'd3;  b_in = rnd128();
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        strm     = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        chk("stream_stalls", stalls, 0);
        chk("stream_count", n_out, n_in);

        // Alternate mode 0 / mode 2 every beat.
        strm = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk) #1;
            in_valid = 1'b1;  in_mode = (i % 2 == 1) ? 2'd2 : 2'd0;  b_in = rnd128();
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        strm     = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        chk("alt_stalls", stalls, 0);
        chk("alt_count", n_out, n_in);

        // Random valid and 30% out_ready.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk) #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_mode   = 2'($urandom_range(0, 3));
            b_in      = rnd128();
            out_ready = ($urandom_range(0, 9) < 3);
        end
        @(posedge clk) #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (CAP + LAT + 4) @(posedge clk);
        chk("rand_count", n_out, n_in);
        chk("rand_queue_empty", exp_q.size(), 0);

        // Full stall under continuous input, then drain.
        n0 = n_in;
        @(posedge clk) #1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            in_valid = 1'b1;  in_mode = 2'($urandom_range(0, 3));  b_in = rnd128();
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_accepted", n_in - n0, CAP);
        @(posedge clk) #1;
        out_ready = 1'b1;
        repeat (CAP + LAT + 4) @(posedge clk);
        chk("full_drain_count", n_out, n_in);

        // Reset with two beats in flight.
        @(posedge clk) #1;
        mon_en = 1'b0;  in_valid = 1'b1;  in_mode = 2'd3;  b_in = rnd128();
        @(posedge clk) #1;
        b_in = rnd128();
        @(posedge clk) #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk) #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_b_out", b_out, 0);
        chk("midrst_out_mode", out_mode, 0);
        #1;
        exp_q.delete();
        n_in = 0;  n_out = 0;  hold = 1'b0;
        mon_en = 1'b1;
        main_lat("post_rst");
        repeat (LAT + 4) @(posedge clk);
        chk("post_rst_single", n_out, 1);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
